alu_muldiv_seq: RTL and testbench

//  Multi-cycle unsigned multiply/divide sequencer that borrows the shared

---
 rtl/alu_muldiv_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer driving a shared WIDTH-bit ALU.
// Shift-add multiply and restoring divide, one ALU add per cycle.
module alu_muldiv_seq #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] OPER_ADD = 4'b0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dz,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_InA,
  output logic [WIDTH-1:0] alu_InB,
  output logic             alu_Cin,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  output logic [3:0]       alu_Oper,
  output logic [1:0]       alu_instruct,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_CF
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic               dz_q, dz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               res_dz_q, res_dz_d;

  logic               run;
  logic [WIDTH-1:0]   trial;
  logic               div_take;
  logic [WIDTH-1:0]   acc_nxt, mq_nxt;

  assign run   = (state_q == RUN);
  assign trial = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};

  // acc_q holds the partial product high half (MUL) or the remainder (DIV);
  // mq_q holds the multiplier/product low half or the dividend/quotient.
  always_comb begin
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Cin  = 1'b0;
    alu_invB = 1'b0;
    div_take = acc_q[WIDTH-1] | alu_CF;
    if (op_q) begin
      acc_nxt = div_take ? alu_Out : trial;
      mq_nxt  = {mq_q[WIDTH-2:0], div_take};
    end else begin
      acc_nxt = {alu_CF, alu_Out[WIDTH-1:1]};
      mq_nxt  = {alu_Out[0], mq_q[WIDTH-1:1]};
    end
    if (run) begin
      if (op_q) begin
        alu_InA  = trial;
        alu_InB  = mc_q;
        alu_invB = 1'b1;
        alu_Cin  = 1'b1;
      end else begin
        alu_InA = acc_q;
        alu_InB = mq_q[0] ? mc_q : '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    mc_d     = mc_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_dz_d = res_dz_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RUN;
          op_d    = req_op;
          dz_d    = req_op && (req_b == '0);
          cnt_d   = '0;
          acc_d   = '0;
          mq_d    = req_a;
          mc_d    = req_b;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_nxt;
        mq_d  = mq_nxt;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          res_hi_d = acc_nxt;
          res_lo_d = mq_nxt;
          res_dz_d = dz_q;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      mc_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_dz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      mc_q     <= mc_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_dz_q <= res_dz_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign res_valid    = (state_q == DONE);
  assign res_hi       = res_hi_q;
  assign res_lo       = res_lo_q;
  assign res_dz       = res_dz_q;
  assign alu_own      = run;
  assign alu_invA     = 1'b0;
  assign alu_sign     = 1'b0;
  assign alu_Oper     = run ? OPER_ADD : 4'b0000;
  assign alu_instruct = 2'b00;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural ALU and a plain-arithmetic
// reference model for products, quotients and remainders.
module tb_alu_muldiv_seq;

  localparam int         W        = 16;
  localparam logic [3:0] OPER_ADD = 4'b0100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_hi, res_lo;
  logic         res_dz;
  logic         alu_own;
  logic [W-1:0] alu_InA, alu_InB;
  logic         alu_Cin, alu_invA, alu_invB, alu_sign;
  logic [3:0]   alu_Oper;
  logic [1:0]   alu_instruct;
  logic [W-1:0] alu_Out;
  logic         alu_CF;
  logic [W:0]   alu_sum;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } result_t;

  result_t expQ[$];
  int      nChecks = 0;
  int      nFails  = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in: plain adder with optional operand inversion.
  assign alu_sum = {1'b0, (alu_invA ? ~alu_InA : alu_InA)}
                 + {1'b0, (alu_invB ? ~alu_InB : alu_InB)}
                 + {{W{1'b0}}, alu_Cin};
  assign alu_Out = alu_sum[W-1:0];
  assign alu_CF  = alu_sum[W];

  alu_muldiv_seq #(.WIDTH(W), .OPER_ADD(OPER_ADD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .res_dz(res_dz),
    .alu_own(alu_own), .alu_InA(alu_InA), .alu_InB(alu_InB),
    .alu_Cin(alu_Cin), .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Oper(alu_Oper), .alu_instruct(alu_instruct),
    .alu_Out(alu_Out), .alu_CF(alu_CF)
  );

  function automatic result_t refModel(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    logic [2*W-1:0] p;
    if (!op) begin
      p    = a * b;
      r.hi = p[2*W-1:W];
      r.lo = p[W-1:0];
      r.dz = 1'b0;
    end else if (b == '0) begin
      r.hi = a;
      r.lo = '1;
      r.dz = 1'b1;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
      r.dz = 1'b0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake and polices the ALU bus.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_own) begin
        checkOutput("alu_Oper while owned", alu_Oper, OPER_ADD);
        checkOutput("alu_instruct while owned", alu_instruct, 2'b00);
        checkOutput("alu_invA while owned", alu_invA, 1'b0);
        checkOutput("alu_sign while owned", alu_sign, 1'b0);
      end else begin
        checkOutput("alu_InA idle", alu_InA, '0);
        checkOutput("alu_InB idle", alu_InB, '0);
        checkOutput("alu_Cin/invB idle", {alu_Cin, alu_invB}, 2'b00);
      end
      if (res_valid && res_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected result", 1, 0);
        end else begin
          result_t e;
          e = expQ.pop_front();
          checkOutput("res_hi", res_hi, e.hi);
          checkOutput("res_lo", res_lo, e.lo);
          checkOutput("res_dz", res_dz, e.dz);
        end
      end
    end
  end

  task automatic applyStimulus(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input result_t exp, input int stall, input bit checkHold,
                               input bit pulseMid);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("req_ready before accept", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    res_ready = (stall == 0);
    expQ.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    k = 0;
    while (!res_valid && k < 100) begin
      req_valid = (pulseMid && k == 5);
      if (pulseMid && k == 5) checkOutput("req_ready low mid-run", req_ready, 1'b0);
      @(posedge clk); #1;
      k++;
    end
    req_valid = 1'b0;
    checkOutput("latency to res_valid", k, W);
    for (int s = 0; s < stall; s++) begin
      if (checkHold) begin
        checkOutput("hold res_valid", res_valid, 1'b1);
        checkOutput("hold res_hi", res_hi, exp.hi);
        checkOutput("hold res_lo", res_lo, exp.lo);
        checkOutput("hold res_dz", res_dz, exp.dz);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    checkOutput("req_ready low during take", req_ready, 1'b0);
    @(posedge clk); #1;
    checkOutput("req_ready after take", req_ready, 1'b1);
    checkOutput("res_valid after take", res_valid, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    result_t r;
    logic op;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", req_ready, 1'b1);
    checkOutput("reset res_valid", res_valid, 1'b0);
    checkOutput("reset res_dz", res_dz, 1'b0);
    checkOutput("reset alu_own", alu_own, 1'b0);
    checkOutput("reset res_hi/lo", {res_hi, res_lo}, 32'h0);
    @(posedge clk); #1;

    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, '{16'hFFFE, 16'h0001, 1'b0}, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'd1000, 16'd7,    '{16'd6, 16'd142, 1'b0},      0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 16'h8001, '{16'h7FFE, 16'h0001, 1'b0}, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 16'h0000, '{16'h1234, 16'hFFFF, 1'b1}, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd3, 16'd5,       '{16'h0000, 16'h000F, 1'b0}, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'd3, 16'd5,       '{16'h0000, 16'h000F, 1'b0}, 5, 1'b1, 1'b1);

    // Abort a divide after eight iterations; nothing from it may surface.
    req_valid = 1'b1; req_op = 1'b1; req_a = 16'hBEEF; req_b = 16'h0013;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checkOutput("alu_own before abort", alu_own, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort req_ready", req_ready, 1'b1);
    checkOutput("abort res_valid", res_valid, 1'b0);
    checkOutput("abort alu_own", alu_own, 1'b0);
    checkOutput("abort res_dz", res_dz, 1'b0);
    checkOutput("abort res_hi/lo", {res_hi, res_lo}, 32'h0);
    checkOutput("abort alu_InA/InB", {alu_InA, alu_InB}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'h1234, 16'h0010, '{16'h0001, 16'h2340, 1'b0}, 0, 1'b0, 1'b0);

    for (int i = 0; i < 2000 && nFails < 20; i++) begin
      op = 1'($urandom);
      a  = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      r = refModel(op, a, b);
      applyStimulus(op, a, b, r, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
